bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on ser_out, which drives the detector's serial input x. Back-to-back words stream with no idle gap. Between words the line is held at IDLE_BIT, with ser_valid low.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2
LSB_FIRST, 0, 0 = MSB transmitted first, 1 = LSB transmitted first
IDLE_BIT, 1'b0, level driven on ser_out when no word is being shifted

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents a word on in_data
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  parallel word; sampled only on acceptance
ser_out  output  1  serial bit stream (feeds detector x)
ser_valid  output  1  high while ser_out carries a data bit
sof  output  1  high with the first bit of each word
eof  output  1  high with the last bit of each word
busy  output  1  high in SHIFT state

Behaviour:
- Reset is synchronous and active-high, clock is clk.
- Reset values: state=IDLE, bit_cnt=0, ser_out=IDLE_BIT, ser_valid=0, sof=0, eof=0, busy=0.
- While reset is high, in_ready=0.
- Reset mid-word: remaining bits are dropped. The next cycle after reset deasserts, the block is in IDLE and ready.
- FSM states (shared enum): IDLE, SHIFT.
- in_ready is combinational from state and bit_cnt only, never from in_valid:
  - in_ready=1 in IDLE.
  - in_ready=1 in SHIFT when bit_cnt==WIDTH-1 (last bit on the line).
  - in_ready=0 otherwise.
- Accept = in_valid && in_ready. On accept, in_data is loaded into the shift register. Later changes to in_data are ignored.
- Latency: the first bit of an accepted word appears on ser_out in the cycle after acceptance. A word occupies exactly WIDTH consecutive cycles.
- Outputs ser_out, ser_valid, sof and eof are registered (no combinational path from inputs).
- Transitions:
  - IDLE, accept -> SHIFT, bit_cnt=0.
  - IDLE, no accept -> IDLE; line held at IDLE_BIT, ser_valid=0.
  - SHIFT, bit_cnt<WIDTH-1 -> SHIFT, bit_cnt+1, shift by one position.
  - SHIFT, bit_cnt==WIDTH-1 with accept -> SHIFT, bit_cnt=0, new word loaded. No gap: sof of the new word is in the cycle immediately after eof.
  - SHIFT, bit_cnt==WIDTH-1 without accept -> IDLE. The next cycle shows ser_out=IDLE_BIT and ser_valid=0.
- Bit order:
  - LSB_FIRST=0: bit WIDTH-1 first, bit 0 last.
  - LSB_FIRST=1: bit 0 first, bit WIDTH-1 last.
- bit_cnt width is $clog2(WIDTH); it never exceeds WIDTH-1, with no wrap past it.
- sof is high when bit_cnt==0 in SHIFT; eof is high when bit_cnt==WIDTH-1 in SHIFT. Both are high only alongside ser_valid.
- busy = (state==SHIFT).
- in_valid may drop or hold at any time. A word is committed only on accept; there is no retraction after acceptance.

Decomposition:
- Shared package ser_pkg holds:
  - the ser_state_t enum {IDLE, SHIFT};
  - the default IDLE_BIT constant;
  - the standard test word constants used by the detector and serializer benches (e.g. 8'h99).
- No sub-module. The shift register, counter and FSM are inline, because the datapath is a single register.

Test Plan:
- Reset, then in_valid=1 with in_data=8'h99 and LSB_FIRST=0 -> accepted in the first cycle. ser_out=1,0,0,1,1,0,0,1 over the next 8 cycles, sof on cycle 1, eof on cycle 8. When fed to the detector, y pulses after the 4th and 7th bits.
- Back-to-back words 8'hA5 then 8'h3C, with in_valid held -> 16 contiguous ser_valid cycles, eof then sof with no gap. in_ready is high only in IDLE and on the last-bit cycles.
- Single word 8'hF0 followed by in_valid=0 -> after eof, ser_out=IDLE_BIT, ser_valid=0 and busy=0 the next cycle, and in_ready=1.
- reset pulsed for 1 cycle on the 4th bit of 8'hFF -> the remaining bits are dropped and all outputs return to reset values. A new word 8'h81 accepted afterwards serializes fully and correctly.
- LSB_FIRST=1, in_data=8'h01 -> ser_out=1,0,0,0,0,0,0,0.
- in_data changed to 8'h00 on the cycle after accepting 8'hC3 -> output remains 1,1,0,0,0,0,1,1.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the serial link: FSM state encoding, line idle level
// and the standard test words used by the serializer and detector benches.
package ser_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam logic SER_IDLE_BIT = 1'b0;

    localparam logic [7:0] TEST_WORD_99 = 8'h99;
    localparam logic [7:0] TEST_WORD_A5 = 8'hA5;
    localparam logic [7:0] TEST_WORD_3C = 8'h3C;
    localparam logic [7:0] TEST_WORD_F0 = 8'hF0;
    localparam logic [7:0] TEST_WORD_FF = 8'hFF;
    localparam logic [7:0] TEST_WORD_81 = 8'h81;
    localparam logic [7:0] TEST_WORD_01 = 8'h01;
    localparam logic [7:0] TEST_WORD_C3 = 8'hC3;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on valid/ready and shifts
// them out one bit per clock with sof/eof framing and no gap between words.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   LSB_FIRST = 1'b0,
    parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       state_r, state_n_s;
    logic [CNT_W-1:0] bit_cnt_r, bit_cnt_n_s;
    logic [WIDTH-1:0] shreg_r, shreg_n_s;
    logic             ser_out_r, ser_out_n_s;
    logic             ser_valid_r, ser_valid_n_s;
    logic             sof_r, sof_n_s;
    logic             eof_r, eof_n_s;
    logic             last_bit_s;
    logic             in_ready_s;
    logic             accept_s;

    function automatic logic first_bit(input logic [WIDTH-1:0] word);
        return LSB_FIRST ? word[0] : word[WIDTH-1];
    endfunction

    // shreg holds the bits not yet on the line, aligned so first_bit() picks the next one
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
        return LSB_FIRST ? {1'b0, word[WIDTH-1:1]} : {word[WIDTH-2:0], 1'b0};
    endfunction

    // Handshake: ready in IDLE or while the last bit of a word is on the line
    always_comb begin
        last_bit_s = (state_r == SHIFT) && (bit_cnt_r == LAST_CNT);
        if (reset) begin
            in_ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = last_bit_s;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Next-state and next-output computation
    always_comb begin
        state_n_s     = state_r;
        bit_cnt_n_s   = bit_cnt_r;
        shreg_n_s     = shreg_r;
        ser_out_n_s   = IDLE_BIT;
        ser_valid_n_s = 1'b0;
        sof_n_s       = 1'b0;
        eof_n_s       = 1'b0;
        if (accept_s) begin
            state_n_s     = SHIFT;
            bit_cnt_n_s   = {CNT_W{1'b0}};
            shreg_n_s     = shift_word(in_data);
            ser_out_n_s   = first_bit(in_data);
            ser_valid_n_s = 1'b1;
            sof_n_s       = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n_s = IDLE;
                end
                SHIFT: begin
                    if (last_bit_s) begin
                        state_n_s   = IDLE;
                        bit_cnt_n_s = {CNT_W{1'b0}};
                    end else begin
                        bit_cnt_n_s   = bit_cnt_r + CNT_W'(1);
                        shreg_n_s     = shift_word(shreg_r);
                        ser_out_n_s   = first_bit(shreg_r);
                        ser_valid_n_s = 1'b1;
                        eof_n_s       = ((bit_cnt_r + CNT_W'(1)) == LAST_CNT);
                    end
                end
                default: begin
                    state_n_s   = IDLE;
                    bit_cnt_n_s = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and registered line outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            bit_cnt_r   <= {CNT_W{1'b0}};
            shreg_r     <= {WIDTH{1'b0}};
            ser_out_r   <= IDLE_BIT;
            ser_valid_r <= 1'b0;
            sof_r       <= 1'b0;
            eof_r       <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            bit_cnt_r   <= bit_cnt_n_s;
            shreg_r     <= shreg_n_s;
            ser_out_r   <= ser_out_n_s;
            ser_valid_r <= ser_valid_n_s;
            sof_r       <= sof_n_s;
            eof_r       <= eof_n_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign ser_out   = ser_out_r;
    assign ser_valid = ser_valid_r;
    assign sof       = sof_r;
    assign eof       = eof_r;
    assign busy      = (state_r == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) share one stimulus
// stream; each accepted word is expanded into its expected bit sequence.
module tb_bit_serializer;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;

    logic rdy0, out0, val0, sof0, eof0, busy0;
    logic rdy1, out1, val1, sof1, eof1, busy1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic b_msb;
        logic b_lsb;
        logic sof;
        logic eof;
    } exp_t;

    exp_t exp_q[$];

    bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_BIT(IDLE)) dut_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .ser_out(out0), .ser_valid(val0), .sof(sof0),
        .eof(eof0), .busy(busy0)
    );

    bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_BIT(IDLE)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .ser_out(out1), .ser_valid(val1), .sof(sof1),
        .eof(eof1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: compare one line cycle per negedge, then record any acceptance
    initial begin
        exp_t e;
        logic have;
        logic exp_rdy;
        forever begin
            @(negedge clk);
            have = 1'b0;
            e = '{b_msb: IDLE, b_lsb: IDLE, sof: 1'b0, eof: 1'b0};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                have = 1'b1;
            end
            chk("ser_out_msb", out0, e.b_msb);
            chk("ser_out_lsb", out1, e.b_lsb);
            chk("ser_valid_msb", val0, have);
            chk("ser_valid_lsb", val1, have);
            chk("sof_msb", sof0, e.sof);
            chk("sof_lsb", sof1, e.sof);
            chk("eof_msb", eof0, e.eof);
            chk("eof_lsb", eof1, e.eof);
            chk("busy_msb", busy0, have);
            chk("busy_lsb", busy1, have);
            exp_rdy = !reset && (exp_q.size() == 0);
            chk("in_ready_msb", rdy0, exp_rdy);
            chk("in_ready_lsb", rdy1, exp_rdy);
            if (reset) begin
                exp_q.delete();
            end else if (in_valid && exp_rdy) begin
                for (int i = 0; i < W; i++) begin
                    exp_q.push_back('{b_msb: in_data[W-1-i], b_lsb: in_data[i],
                                      sof: (i == 0), eof: (i == W-1)});
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] after);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = after;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout word=%h: in_ready never 1 within 50 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        send(8'h99, 8'h00);
        idle(10);
        send(8'hA5, 8'h11);
        send(8'h3C, 8'h22);
        idle(10);
        send(8'hF0, 8'h33);
        idle(10);

        send(8'hFF, 8'h00);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(8'h81, 8'h00);
        idle(10);

        send(8'h01, 8'h00);
        idle(10);
        send(8'hC3, 8'h00);
        idle(10);

        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = W'($urandom);
            reset    = ($urandom_range(0, 59) == 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
